// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared state encoding, widths and sizing helpers for the PLL reset sequencer
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;

  // Bits needed to represent every value 0..max_val, never fewer than one.
  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// rtl/pll_reset_sequencer_bit_sync.sv - two-flop synchronizer with synchronous clear
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - holds the PLL in reset, waits for stable lock, then releases the system reset
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  fail,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CNT_W = bits_for(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES) - 1);
  localparam int RTY_W = bits_for(MAX_RETRIES - 1);

  localparam logic [CNT_W-1:0]      RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0]      RTY_LAST    = RTY_W'(MAX_RETRIES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retries;
  logic             retry_inc;
  logic             locked_s;

  bit_sync u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Lock beats the timeout in WAIT_LOCK; a drop beats the terminal count in STABLE.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retries == RTY_LAST) begin
            state_nxt = FAIL;
          end else begin
            state_nxt = PLL_RST;
            retry_inc = 1'b1;
          end
        end
      end
      STABLE: begin
        if (!locked_s)                state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = RUN;
      end
      RUN: begin
        if (!locked_s) state_nxt = PLL_RST;
      end
      FAIL:    state_nxt = FAIL;
      default: state_nxt = PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= PLL_RST;
      cnt        <= '0;
      retries    <= '0;
      loss_count <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      fail       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)
        cnt <= '0;
      else if (state != RUN && state != FAIL)
        cnt <= cnt + CNT_W'(1);

      if (state == RUN)
        retries <= '0;
      else if (retry_inc)
        retries <= retries + RTY_W'(1);

      if (state == RUN && state_nxt == PLL_RST && loss_count != LOSS_MAX)
        loss_count <= loss_count + LOSS_CNT_W'(1);

      pll_rst <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
      sys_rst <= (state_nxt != RUN);
      fail    <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - randomized directed bench with an edge-arithmetic reference model
module tb_pll_reset_sequencer;

  localparam int PRC     = 4;
  localparam int LTC     = 32;
  localparam int LSC     = 8;
  localparam int MR      = 3;
  localparam int ATTEMPT = PRC + LTC;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       fail;
  logic [7:0] loss_count;

  int total = 0;
  int bad   = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .LOCK_STABLE_CYCLES  (LSC),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .fail       (fail),
    .loss_count (loss_count)
  );

  always #5 refclk = ~refclk;

  // Reference model: expectations in edges, derived from the timing rules.
  function automatic int exp_lock_release();
    return LSC + 2;
  endfunction

  function automatic int exp_pll_edge(input int idx);
    if (idx % 2 == 0) return PRC + ATTEMPT * (idx / 2);
    return ATTEMPT * ((idx + 1) / 2);
  endfunction

  function automatic int exp_relock(input int r);
    int stable_entry;
    stable_entry = (PRC + 3 > r + 5) ? PRC + 3 : r + 5;
    return stable_entry + LSC - (2 + r);
  endfunction

  function automatic int exp_loss(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return sys_rst;
      default: return fail;
    endcase
  endfunction

  task automatic edges_until(input int which, input logic val, input int limit, output int n);
    n = 0;
    while (sig(which) !== val) begin
      if (n >= limit) begin
        n = -1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    locked = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic bring_up(input int k);
    int n;
    do_reset();
    edges_until(0, 1'b0, 50, n);
    chk("pll_rst_hold", n, PRC);
    repeat (k) tick();
    locked = 1'b1;
    edges_until(1, 1'b0, 100, n);
    chk("lock_to_release", n - 1, exp_lock_release());
    chk("bringup_fail_low", fail, 0);
    chk("bringup_pll_rst_low", pll_rst, 0);
  endtask

  initial begin
    int n, s, g, k, a, r, e;
    int edges[$];
    logic prev;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_sys_rst", sys_rst, 1);
    chk("reset_fail", fail, 0);
    chk("reset_loss_count", loss_count, 0);

    // Normal bring-up, nominal, lock-wins-at-timeout boundary, and random delays
    bring_up(9);
    bring_up(LTC - 3);
    for (int t = 0; t < 4; t++) bring_up($urandom_range(0, LTC - 3));

    // Glitchy lock in STABLE; first trial drops exactly onto the stable terminal count
    for (int t = 0; t < 6; t++) begin
      s = (t == 0) ? 5 : $urandom_range(0, 5);
      g = (t == 0) ? 3 : $urandom_range(1, 4);
      k = $urandom_range(0, 10);
      do_reset();
      edges_until(0, 1'b0, 50, n);
      repeat (k) tick();
      locked = 1'b1;
      repeat (3 + s) tick();
      locked = 1'b0;
      repeat (g) tick();
      chk("glitch_sys_rst_held", sys_rst, 1);
      locked = 1'b1;
      edges_until(1, 1'b0, 100, n);
      chk("glitch_release", n - 1, exp_lock_release());
    end

    // Timeout retries followed by success
    for (int t = 0; t < 3; t++) begin
      a = (t == 0) ? 2 : $urandom_range(0, 2);
      do_reset();
      edges.delete();
      e = 0;
      prev = 1'b1;
      while (edges.size() < 2 * a + 1 && e < 300) begin
        tick();
        e++;
        if (pll_rst !== prev) begin
          edges.push_back(e);
          prev = pll_rst;
        end
      end
      chk("retry_transition_count", edges.size(), 2 * a + 1);
      foreach (edges[i]) chk("retry_edge", edges[i], exp_pll_edge(i));
      chk("retry_fail_low", fail, 0);
      repeat ($urandom_range(0, 20)) tick();
      locked = 1'b1;
      edges_until(1, 1'b0, 100, n);
      chk("retry_release", n - 1, exp_lock_release());
      chk("retry_fail_after", fail, 0);
    end

    // Retry exhaustion
    do_reset();
    edges_until(2, 1'b1, 400, n);
    chk("fail_edge", n, MR * ATTEMPT);
    chk("fail_pll_rst", pll_rst, 1);
    chk("fail_sys_rst", sys_rst, 1);
    repeat (40) begin
      locked = 1'($urandom_range(0, 1));
      tick();
      chk("fail_sticky", fail, 1);
      chk("fail_pll_rst_hold", pll_rst, 1);
      chk("fail_sys_rst_hold", sys_rst, 1);
    end
    locked = 1'b1;
    repeat (20) tick();
    chk("fail_sticky_locked", fail, 1);
    rst = 1'b1;
    tick();
    chk("fail_cleared", fail, 0);
    chk("fail_rst_pll_rst", pll_rst, 1);

    // Loss in RUN, saturating loss counter
    bring_up($urandom_range(0, 20));
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b0;
      tick();
      tick();
      chk("loss_sys_rst_e1", sys_rst, 0);
      tick();
      chk("loss_sys_rst_e2", sys_rst, 1);
      chk("loss_pll_rst_e2", pll_rst, 1);
      chk("loss_count", loss_count, exp_loss(i));
      r = $urandom_range(0, 3);
      repeat (r) tick();
      locked = 1'b1;
      edges_until(1, 1'b0, 60, n);
      chk("relock_latency", n, exp_relock(r));
    end

    // Reset during RUN
    rst = 1'b1;
    tick();
    chk("run_rst_pll_rst", pll_rst, 1);
    chk("run_rst_sys_rst", sys_rst, 1);
    chk("run_rst_loss_count", loss_count, 0);
    chk("run_rst_fail", fail, 0);
    rst = 1'b0;
    edges_until(0, 1'b0, 50, n);
    chk("run_rst_pll_hold", n, PRC);

    // Reset during STABLE with a nonzero loss count
    edges_until(1, 1'b0, 100, n);
    locked = 1'b0;
    repeat (3) tick();
    chk("stable_pre_loss", loss_count, 1);
    locked = 1'b1;
    repeat (5 + $urandom_range(0, 6)) tick();
    chk("stable_pre_sys_rst", sys_rst, 1);
    rst = 1'b1;
    tick();
    chk("stable_rst_pll_rst", pll_rst, 1);
    chk("stable_rst_sys_rst", sys_rst, 1);
    chk("stable_rst_loss_count", loss_count, 0);
    rst = 1'b0;
    edges_until(0, 1'b0, 50, n);
    chk("stable_rst_pll_hold", n, PRC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
